sv_req_grant_arbiter: RTL

- Shares a single resource between N requesters using one-hot grants.
- Two arbitration modes, selectable per arbitration: fixed priority (first match wins, lowest index highest) and round-robin (rotating priority).
- Grants persist until the owner drops its request or a hold-time limit expires.
- Sits in front of a shared datapath unit in SV regression tests and exercises priority/unique decision chains in sequential logic.

---
 rtl/sv_req_grant_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sv_req_grant_arbiter.sv
// ---------------------------------------------------------------------------
// sv_req_grant_arbiter
//
// Shares one resource between N requesters with one-hot grants. The mode
// input selects the arbitration policy each time a new owner is picked:
// fixed priority (lowest index wins) or round-robin (scan upward from the
// previous winner, wrapping). A grant lasts until its owner drops its
// request or until MAX_HOLD cycles have elapsed. There is always at least
// one idle cycle between two grants.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high
//   req      request vector, bit i = requester i wants/uses the resource
//   mode     0 = fixed priority, 1 = round-robin (used only when arbitrating)
//   gnt      one-hot grant, or all zeros
//   gnt_id   index of the asserted gnt bit, 0 when no grant
//   busy     high while any gnt bit is high
//   timeout  one-cycle pulse in the bubble after a hold-limit revoke
// ---------------------------------------------------------------------------
module sv_req_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_id,
    output logic         busy,
    output logic         timeout
);

    localparam int            HW        = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [2:0]    LAST_INIT = 3'(N - 1);

    // REVOKE is an idle cycle that also flags the hold-limit timeout; it
    // arbitrates exactly like IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REVOKE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    owner;
    logic [2:0]    owner_nxt;
    logic [2:0]    last;
    logic [2:0]    last_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_nxt;
    logic [N-1:0]  owner_mask;
    logic          owner_req;
    logic [2:0]    winner;

    // Lowest set index wins; scanning downward leaves the lowest one last.
    function automatic logic [2:0] pick_fixed(input logic [N-1:0] r);
        logic [2:0] w;
        w = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) begin
                w = 3'(i);
            end
        end
        return w;
    endfunction

    // First set bit after the previous winner, wrapping N-1 -> 0. The scan
    // covers all N positions so the previous winner itself is considered last.
    function automatic logic [2:0] pick_rr(input logic [N-1:0] r, input logic [2:0] l);
        logic [2:0] w;
        logic       found;
        int         idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(l) + k) % N;
            if (!found && r[idx]) begin
                w     = 3'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign owner_mask = N'(1) << owner;
    assign owner_req  = |(req & owner_mask);
    assign winner     = mode ? pick_rr(req, last) : pick_fixed(req);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= LAST_INIT;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        hold_cnt_nxt = hold_cnt;
        unique case (state)
            IDLE, REVOKE: begin
                if (|req) begin
                    state_nxt    = GRANT;
                    owner_nxt    = winner;
                    last_nxt     = winner;
                    hold_cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                // Release is checked first so it beats a coincident hold limit.
                priority if (!owner_req) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = REVOKE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode; purely from state so reset clears outputs immediately.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        busy    = 1'b0;
        timeout = 1'b0;
        if (state == GRANT) begin
            gnt    = owner_mask;
            gnt_id = owner;
            busy   = 1'b1;
        end
        if (state == REVOKE) begin
            timeout = 1'b1;
        end
    end

endmodule
